// File: rtl/ps2_pkg.sv
// Shared types and Set-2 scancode constants for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } frame_state_t;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam logic [7:0] PS2_BAT_OK = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ERR0   = 8'h00;
    localparam logic [7:0] PS2_ERR1   = 8'hFF;

    localparam int unsigned PS2_PAUSE_SKIP = 7;
    localparam int unsigned SKIP_W         = $clog2(PS2_PAUSE_SKIP + 1);

    // Device status/response bytes that never represent a key.
    function automatic logic is_status_byte(input logic [7:0] b);
        logic hit;
        hit = 1'b0;
        case (b)
            PS2_BAT_OK, PS2_ACK, PS2_ECHO, PS2_RESEND, PS2_ERR0, PS2_ERR1: hit = 1'b1;
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus glitch filter for the PS/2 clock line; emits a
// one-cycle pulse on each filtered falling edge.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_raw,
    output logic fall_pulse
);

    localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

    logic [1:0]       sync_q;
    logic             filt_q;
    logic             fall_q;
    logic [CNT_W-1:0] cnt_q;
    logic             line_sync;

    assign line_sync  = sync_q[1];
    assign fall_pulse = fall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[0], line_raw};
        end
    end

    // cnt_q counts consecutive samples that disagree with the filtered value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= 1'b1;
            cnt_q  <= '0;
            fall_q <= 1'b0;
        end else begin
            fall_q <= 1'b0;
            if (line_sync != filt_q) begin
                if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                    filt_q <= line_sync;
                    cnt_q  <= '0;
                    fall_q <= ~line_sync;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_scancode_receiver.sv
// PS/2 device-to-host frame receiver with Set-2 prefix stripping; emits one
// keycode event per make/break with break and extended flags.
module ps2_scancode_receiver
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       key_data_stb,
    output logic [7:0] key_data,
    output logic       key_broken,
    output logic       key_extended,
    output logic       frame_error
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic              fall;
    logic [1:0]        data_sync_q;
    logic              data_s;

    frame_state_t      state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              par_q, par_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              ext_q, ext_d;
    logic              brk_q, brk_d;
    logic [SKIP_W-1:0] skip_q, skip_d;
    logic              stb_q, stb_d;
    logic [7:0]        data_q, data_d;
    logic              broken_q, broken_d;
    logic              extended_q, extended_d;
    logic              err_q, err_d;
    logic              tmo_expired;

    ps2_line_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .clk       (clk),
        .rst_n     (rst_n),
        .line_raw  (ps2_clk),
        .fall_pulse(fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_sync_q <= '1;
        end else begin
            data_sync_q <= {data_sync_q[0], ps2_data};
        end
    end

    assign data_s = data_sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tmo_q      <= '0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            skip_q     <= '0;
            stb_q      <= 1'b0;
            data_q     <= '0;
            broken_q   <= 1'b0;
            extended_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tmo_q      <= tmo_d;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            skip_q     <= skip_d;
            stb_q      <= stb_d;
            data_q     <= data_d;
            broken_q   <= broken_d;
            extended_q <= extended_d;
            err_q      <= err_d;
        end
    end

    // A falling edge in the expiry cycle takes priority over the timeout.
    assign tmo_expired = (state_q != IDLE) && !fall &&
                         (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        tmo_d      = tmo_q;
        ext_d      = ext_q;
        brk_d      = brk_q;
        skip_d     = skip_q;
        stb_d      = 1'b0;
        data_d     = data_q;
        broken_d   = broken_q;
        extended_d = extended_q;
        err_d      = 1'b0;

        if (fall) begin
            tmo_d = '0;
            case (state_q)
                IDLE: begin
                    if (!data_s) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    par_d   = data_s;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (data_s && (^{shift_q, par_q})) begin
                        if (skip_q != '0) begin
                            skip_d = skip_q - 1'b1;
                        end else if (shift_q == PS2_PAUSE) begin
                            skip_d = SKIP_W'(PS2_PAUSE_SKIP);
                        end else if (shift_q == PS2_EXT) begin
                            ext_d = 1'b1;
                        end else if (shift_q == PS2_BRK) begin
                            brk_d = 1'b1;
                        end else if (!is_status_byte(shift_q)) begin
                            stb_d      = 1'b1;
                            data_d     = shift_q;
                            broken_d   = brk_q;
                            extended_d = ext_q;
                            ext_d      = 1'b0;
                            brk_d      = 1'b0;
                        end
                    end else begin
                        err_d  = 1'b1;
                        ext_d  = 1'b0;
                        brk_d  = 1'b0;
                        skip_d = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (tmo_expired) begin
            state_d = IDLE;
            tmo_d   = '0;
            err_d   = 1'b1;
            ext_d   = 1'b0;
            brk_d   = 1'b0;
            skip_d  = '0;
        end else if (state_q != IDLE) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    assign key_data_stb = stb_q;
    assign key_data     = data_q;
    assign key_broken   = broken_q;
    assign key_extended = extended_q;
    assign frame_error  = err_q;

endmodule

// File: doc/ps2_scancode_receiver.md
# ps2_scancode_receiver

Receives the raw PS/2 keyboard clock/data lines, deserialises 11-bit device-to-host frames and strips Set-2 prefix bytes (E0, F0, E1). Emits one keycode event per make or break, with break and extended flags. Sits directly upstream of the keycode-to-ASCII converter and drives its `key_data_stb`, `key_broken` and `key_data` inputs. Host-to-device transmission is out of scope.

## Interface
- `FILTER_LEN`, default 8: consecutive identical synchronised samples required before the filtered PS/2 clock changes state.
- `TIMEOUT_CYCLES`, default 50000: `clk` cycles allowed between falling edges inside a frame before it is abandoned.
- `clk`  in  1  system clock; the only clock in the block.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ps2_clk`  in  1  raw PS/2 clock, asynchronous to `clk`.
- `ps2_data`  in  1  raw PS/2 data, asynchronous to `clk`.
- `key_data_stb`  out  1  high for exactly one cycle per decoded keycode event.
- `key_data`  out  8  scancode byte with prefixes removed; held between strobes.
- `key_broken`  out  1  event is a key release (F0 prefix); held between strobes.
- `key_extended`  out  1  event carried an E0 prefix; held between strobes.
- `frame_error`  out  1  one-cycle pulse on parity error, bad stop bit or timeout.

## Operation
- Both lines pass through a 2-FF synchroniser. The clock line is additionally filtered: the filtered value toggles only after `FILTER_LEN` consecutive equal samples. The block acts on the filtered falling edge.
- Data is sampled from the synchronised `ps2_data` in the cycle the falling edge is detected.
- Frame FSM:
  - IDLE: sampled 0 → DATA with bit count 0; sampled 1 → stay in IDLE (spurious edge).
  - DATA: shift LSB first; after the 8th bit → PARITY.
  - PARITY: store the bit → STOP.
  - STOP: → IDLE.
- Frame acceptance at STOP:
  - Valid frame: stop bit = 1 and the 8 data bits plus the parity bit contain an odd number of ones.
  - Invalid frame: pulse `frame_error`, discard the byte, clear all prefix state.
- Prefix layer, applied to valid bytes:
  - E0: set `ext_pend`.
  - F0: set `brk_pend`.
  - E1: load the skip counter with 7; this byte and the next 7 valid bytes are discarded with no strobe (Pause is unsupported).
  - AA, FA, EE, FE, 00, FF: discarded with no strobe; pending flags are unchanged.
  - Any other byte: strobe with `key_data` = byte, `key_broken` = `brk_pend`, `key_extended` = `ext_pend`; then clear both pending flags.
- E0 F0 xx and F0 alone are both legal orderings. E0 12 / E0 59 (fake shift) pass through unchanged and are handled downstream.
- Timeout: in any state other than IDLE, `TIMEOUT_CYCLES` cycles without a falling edge → return to IDLE, pulse `frame_error`, clear prefix state and the skip counter. The timeout counter resets on every falling edge.

## Timing
- Reset values: `key_data_stb`=0, `key_data`=8'h00, `key_broken`=0, `key_extended`=0, `frame_error`=0. FSM is in IDLE, pending flags are 0, skip counter is 0.
- Line-to-edge latency: 2 synchroniser cycles + `FILTER_LEN` cycles.
- `key_data_stb` / `frame_error` assert in cycle N+1, where N is the cycle in which the stop-bit falling edge (or timeout expiry) is detected. `key_data`, `key_broken` and `key_extended` update in the same cycle as the strobe.
- A falling edge and timeout expiry in the same cycle: the edge wins and no timeout occurs.
- `rst_n` asserted mid-frame: all state clears immediately. After release, the next low start bit begins a fresh frame.
- The timeout counter width is `$clog2(TIMEOUT_CYCLES+1)`. The filter counter width is `$clog2(FILTER_LEN+1)`.

## Structure
- Package `ps2_pkg`:
  - frame-state enum: IDLE, DATA, PARITY, STOP;
  - constants `PS2_EXT`=8'hE0, `PS2_BRK`=8'hF0, `PS2_PAUSE`=8'hE1, `PS2_BAT_OK`=8'hAA, `PS2_ACK`=8'hFA, `PS2_ECHO`=8'hEE, `PS2_RESEND`=8'hFE, `PS2_ERR0`=8'h00, `PS2_ERR1`=8'hFF;
  - `PS2_PAUSE_SKIP`=7.
- Sub-module `ps2_line_filter` (synchroniser + glitch filter + falling-edge pulse), instantiated for `ps2_clk`. `ps2_data` uses only the synchroniser.

## Test plan
- Frame 1C (parity 0) → one `key_data_stb`, `key_data`=1C, `key_broken`=0, `key_extended`=0.
- Frames F0, 1C → exactly one strobe, `key_data`=1C, `key_broken`=1, `key_extended`=0.
- Frames E0, F0, 75 → one strobe, `key_data`=75, `key_broken`=1, `key_extended`=1; the next frame 1C → both flags 0.
- Frame 1C with a corrupted parity bit → `frame_error` pulse, no strobe. The next frame 32 decodes to 32.
- 5 bits, then silence → `frame_error` exactly `TIMEOUT_CYCLES` cycles after the 5th edge. A following frame 1C decodes correctly. `ps2_clk` low glitches of `FILTER_LEN`-1 cycles → no edge, no state change.
- Sequence E1 14 77 E1 F0 14 F0 77, then 1C → a single strobe with `key_data`=1C. `rst_n` pulsed after 4 bits of a frame → all outputs at reset values, and the next frame decodes.
